cache_line_xfer: RTL and testbench
==================================

Name: cache_line_xfer

Overview:
- Downstream memory-side stage of the 2-way cache controller.
- Converts the controller's single-cycle line requests into per-word bursts on a word-wide main-memory req/ack bus:
  - mem_write: writeback of an evicted dirty line.
  - mem_read: line fill.
- Assembles the fill line for the data arrays and returns a one-cycle ca_resp when a transfer finishes.
- Replaces fixed-latency fill waiting with a true completion handshake.

Parameters:
- WORDS_PER_LINE, 8, words per cache line (power of 2, >=2).
- WORD_W, 32, data word width in bits.
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for one mm_ack. Used only with LINE_XFER_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  fill request pulse from cache controller
- mem_write  in  1  writeback request pulse from cache controller
- line_addr  in  ADDR_W  byte address of line; offset bits ignored
- wb_line  in  WORDS_PER_LINE*WORD_W  line to write back; word 0 in LSBs
- fill_line  out  WORDS_PER_LINE*WORD_W  assembled fill data; word 0 in LSBs
- ca_resp  out  1  one-cycle completion pulse
- busy  out  1  high whenever state != IDLE
- xfer_err  out  1  one-cycle timeout pulse, coincident with ca_resp
- mm_req  out  1  memory word request
- mm_we  out  1  1 = write, 0 = read
- mm_addr  out  ADDR_W  word-aligned byte address
- mm_wdata  out  WORD_W  write data
- mm_rdata  in  WORD_W  read data, valid when mm_ack is high
- mm_ack  in  1  memory accepted/completed current word

Behaviour:
- Reset:
  - State IDLE.
  - Word index = 0, pending_rd = 0, fill_line = 0.
  - All outputs 0.
  - Reset mid-burst aborts immediately: no ca_resp, mm_req drops in the next cycle.
- Constants:
  - OFF = log2(WORDS_PER_LINE*WORD_W/8).
  - IDX_W = log2(WORDS_PER_LINE).
- Request capture, IDLE only:
  - On a mem_read or mem_write cycle, register line_addr and wb_line.
  - Requests arriving while busy are ignored.
- Simultaneous mem_read and mem_write:
  - Write goes first.
  - pending_rd is set.
  - The fill starts in the cycle after write DONE, with no controller pulse needed.
  - ca_resp pulses once after the write and once after the read.
- States:
  - IDLE: mem_write -> WR_BURST; else mem_read -> RD_BURST.
  - WR_BURST:
    - mm_req=1, mm_we=1.
    - mm_addr = {line_addr[ADDR_W-1:OFF], idx, zeros}.
    - mm_wdata = wb_line word idx.
    - On mm_ack: idx+1. If idx was last -> DONE.
  - RD_BURST:
    - mm_req=1, mm_we=0, mm_addr as above.
    - On mm_ack: mm_rdata is written into fill_line word idx, and idx+1. If idx was last -> DONE.
  - DONE:
    - ca_resp=1 for exactly one cycle. idx=0.
    - If pending_rd: clear it, go to RD_BURST.
    - Otherwise go to IDLE.
- Handshake rules:
  - mm_addr, mm_we and mm_wdata are held stable while mm_req=1 and mm_ack=0.
  - Back-to-back acks give 1 word/cycle; minimum line transfer is WORDS_PER_LINE+1 cycles including DONE.
  - mm_ack while mm_req=0 is ignored.
- fill_line:
  - Updates word-by-word during RD_BURST.
  - Holds its value after DONE until the next read burst.
  - A write burst never modifies it.
- Word index is IDX_W bits and wraps to 0 after the last word. No partial-line transfers.
- Latency: ca_resp arrives WORDS_PER_LINE + total stall cycles + 1 cycles after the request cycle.

Optional Feature:
- LINE_XFER_TIMEOUT_EN defined:
  - A wait counter resets on each mm_ack and on entry to a burst.
  - It increments while mm_req=1 and mm_ack=0.
  - On reaching TIMEOUT_CYCLES: burst aborts, go to DONE with xfer_err=1 alongside ca_resp, and pending_rd is cleared.
- Not defined: no counter, wait is unbounded, xfer_err tied 0.

Decomposition:
- Package cache_pkg:
  - xfer_state_t enum (IDLE, WR_BURST, RD_BURST, DONE).
  - Line geometry constants (WORDS_PER_LINE, WORD_W, OFF, IDX_W).
  - Shared with the cache controller.
- No sub-module needed; the timeout counter is inline under the macro.

Test Plan:
- Read, line_addr=0x0000_1234, mm_ack every cycle, mm_rdata=0xA0+idx -> mm_addr 0x1220..0x123C step 4; fill_line words = 0xA0..0xA7; ca_resp at cycle 9; busy low at cycle 10.
- Write, wb_line words 0x10..0x17, mm_ack stalls 3 cycles on word 2 -> mm_addr/mm_wdata=0x12 held 4 cycles; 8 writes in order; one ca_resp; fill_line unchanged.
- mem_read and mem_write both asserted same cycle -> 8 writes, ca_resp, then 8 reads with no gap beyond DONE, second ca_resp.
- mem_read pulsed during WR_BURST -> ignored; exactly one ca_resp; no read burst.
- rst asserted mid-read at word 4 -> next cycle mm_req=0, busy=0, fill_line=0, no ca_resp.
- With LINE_XFER_TIMEOUT_EN, TIMEOUT_CYCLES=4, mm_ack held 0 -> xfer_err and ca_resp high together on the cycle after 4 wait cycles, then IDLE. Without the macro, still waiting after 1000 cycles.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache geometry and memory-side transfer FSM encoding for the 2-way cache controller.
package cache_pkg;

    localparam int unsigned CACHE_WORDS_PER_LINE = 8;
    localparam int unsigned CACHE_WORD_W         = 32;
    localparam int unsigned CACHE_IDX_W          = $clog2(CACHE_WORDS_PER_LINE);
    localparam int unsigned CACHE_OFF            = $clog2(CACHE_WORDS_PER_LINE * CACHE_WORD_W / 8);

    typedef enum logic [1:0] {
        StIdle,
        StWrBurst,
        StRdBurst,
        StDone
    } xfer_state_t;

endpackage

// File: rtl/cache_line_xfer.sv
// Line writeback/fill engine: splits line requests into per-word req/ack bursts to main memory.
// Optional wait-timeout per word when LINE_XFER_TIMEOUT_EN is defined.
module cache_line_xfer
    import cache_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = CACHE_WORDS_PER_LINE,
    parameter int unsigned WORD_W         = CACHE_WORD_W,
`ifdef LINE_XFER_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
    parameter int unsigned ADDR_W         = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic [ADDR_W-1:0]                line_addr,
    input  logic [WORDS_PER_LINE*WORD_W-1:0] wb_line,
    output logic [WORDS_PER_LINE*WORD_W-1:0] fill_line,
    output logic                             ca_resp,
    output logic                             busy,
    output logic                             xfer_err,
    output logic                             mm_req,
    output logic                             mm_we,
    output logic [ADDR_W-1:0]                mm_addr,
    output logic [WORD_W-1:0]                mm_wdata,
    input  logic [WORD_W-1:0]                mm_rdata,
    input  logic                             mm_ack
);

    localparam int unsigned IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned BYTE_W = $clog2(WORD_W / 8);
    localparam int unsigned OFF    = IDX_W + BYTE_W;
    localparam int unsigned TAG_W  = ADDR_W - OFF;

    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    xfer_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pend_q, pend_d;
    logic [TAG_W-1:0]  addr_q, addr_d;
    line_t             wb_q, wb_d;
    line_t             fill_q, fill_d;
    logic              last_word;
    logic              in_burst;
    logic              timeout_hit;

    // Offset bits of the request address select nothing; the burst regenerates them.
    logic unused_offset;
    assign unused_offset = ^line_addr[OFF-1:0];

    assign last_word = (idx_q == IDX_W'(WORDS_PER_LINE - 1));
    assign in_burst  = (state_q == StWrBurst) || (state_q == StRdBurst);

`ifdef LINE_XFER_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    assign timeout_hit = in_burst && !mm_ack && ((32'(wait_q) + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        wait_d = '0;
        err_d  = 1'b0;
        if (in_burst && !mm_ack) begin
            wait_d = wait_q + 1'b1;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign xfer_err = (state_q == StDone) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign xfer_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mem_write) begin
                    state_d = StWrBurst;
                end else if (mem_read) begin
                    state_d = StRdBurst;
                end
            end
            StWrBurst, StRdBurst: begin
                if ((mm_ack && last_word) || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = pend_q ? StRdBurst : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        pend_d = pend_q;
        addr_d = addr_q;
        wb_d   = wb_q;
        fill_d = fill_q;
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (mem_read || mem_write) begin
                    addr_d = line_addr[ADDR_W-1:OFF];
                    wb_d   = wb_line;
                    pend_d = mem_read && mem_write;
                end
            end
            StWrBurst, StRdBurst: begin
                if (mm_ack) begin
                    idx_d = idx_q + 1'b1;
                    if (state_q == StRdBurst) begin
                        fill_d[idx_q] = mm_rdata;
                    end
                end else if (timeout_hit) begin
                    idx_d  = '0;
                    pend_d = 1'b0;
                end
            end
            StDone: begin
                idx_d  = '0;
                pend_d = 1'b0;
            end
            default: idx_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            pend_q <= 1'b0;
            addr_q <= '0;
            wb_q   <= '0;
            fill_q <= '0;
        end else begin
            idx_q  <= idx_d;
            pend_q <= pend_d;
            addr_q <= addr_d;
            wb_q   <= wb_d;
            fill_q <= fill_d;
        end
    end

    always_comb begin
        mm_req   = in_burst;
        mm_we    = (state_q == StWrBurst);
        mm_addr  = '0;
        mm_wdata = '0;
        if (in_burst) begin
            mm_addr = ADDR_W'({addr_q, idx_q}) << BYTE_W;
        end
        if (state_q == StWrBurst) begin
            mm_wdata = wb_q[idx_q];
        end
        ca_resp = (state_q == StDone);
        busy    = (state_q != StIdle);
    end

    assign fill_line = fill_q;

endmodule

// File: tb/tb_cache_line_xfer.sv
// Directed bench for cache_line_xfer: fill, stalled writeback, combined write+read, ignored
// request, mid-burst reset and the unbounded/timeout wait (LINE_XFER_TIMEOUT_EN).
module tb_cache_line_xfer;

    localparam int unsigned WPL = 8;
    localparam int unsigned WW  = 32;
    localparam int unsigned AW  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     line_addr;
    logic [WPL*WW-1:0] wb_line;
    logic [WPL*WW-1:0] fill_line;
    logic              ca_resp;
    logic              busy;
    logic              xfer_err;
    logic              mm_req;
    logic              mm_we;
    logic [AW-1:0]     mm_addr;
    logic [WW-1:0]     mm_wdata;
    logic [WW-1:0]     mm_rdata;
    logic              mm_ack;

    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;

    always #5 clk = ~clk;

    // Memory model: word at in-line index k reads as 0xA0 + k.
    assign mm_rdata = 32'h000000A0 + {29'd0, mm_addr[4:2]};

    always @(posedge clk) begin
        if (ca_resp) resp_cnt <= resp_cnt + 1;
    end

    cache_line_xfer #(
        .WORDS_PER_LINE(WPL),
        .WORD_W        (WW),
`ifdef LINE_XFER_TIMEOUT_EN
        .TIMEOUT_CYCLES(4),
`endif
        .ADDR_W        (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .line_addr(line_addr),
        .wb_line  (wb_line),
        .fill_line(fill_line),
        .ca_resp  (ca_resp),
        .busy     (busy),
        .xfer_err (xfer_err),
        .mm_req   (mm_req),
        .mm_we    (mm_we),
        .mm_addr  (mm_addr),
        .mm_wdata (mm_wdata),
        .mm_rdata (mm_rdata),
        .mm_ack   (mm_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [WPL*WW-1:0] exp_fill;
        logic [WPL*WW-1:0] wb_pat;
        int                base;
        int                stall;
        logic              req_seen;

        for (int i = 0; i < WPL; i++) begin
            exp_fill[i*WW +: WW] = 32'hA0 + i;
            wb_pat[i*WW +: WW]   = 32'h10 + i;
        end

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        line_addr = '0; wb_line = '0; mm_ack = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", mm_req, 0);
        chk("rst_resp", ca_resp, 0);
        chk("rst_err", xfer_err, 0);
        chk("rst_addr", mm_addr, 0);
        chk("rst_fill", fill_line, 0);
        rst = 1'b0;
        tick();

        // Fill with ack every cycle: ca_resp 9 cycles after the request, idle at 10.
        line_addr = 32'h0000_1234; mem_read = 1'b1; mm_ack = 1'b1;
        tick();
        mem_read = 1'b0;
        for (int k = 0; k < WPL; k++) begin
            chk("rd_req", mm_req, 1);
            chk("rd_we", mm_we, 0);
            chk("rd_addr", mm_addr, 32'h1220 + 4 * k);
            chk("rd_noresp", ca_resp, 0);
            tick();
        end
        chk("rd_resp", ca_resp, 1);
        chk("rd_busy_done", busy, 1);
        chk("rd_fill", fill_line, exp_fill);
        tick();
        chk("rd_idle", busy, 0);
        chk("rd_resp_clr", ca_resp, 0);

        // Writeback with a 3-cycle stall on word 2.
        base = resp_cnt;
        line_addr = 32'h0000_5600; wb_line = wb_pat; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        wb_line = '1;
        for (int k = 0; k < WPL; k++) begin
            stall = (k == 2) ? 3 : 0;
            for (int s = 0; s <= stall; s++) begin
                chk("wr_req", mm_req, 1);
                chk("wr_we", mm_we, 1);
                chk("wr_addr", mm_addr, 32'h5600 + 4 * k);
                chk("wr_data", mm_wdata, 32'h10 + k);
                mm_ack = (s == stall);
                tick();
            end
        end
        chk("wr_resp", ca_resp, 1);
        chk("wr_fill_kept", fill_line, exp_fill);
        tick();
        chk("wr_idle", busy, 0);
        chk("wr_resp_cnt", resp_cnt - base, 1);

        // Simultaneous write+read: writeback, DONE, then fill with no controller pulse.
        base = resp_cnt;
        fill_line_clear_check: begin end
        line_addr = 32'h0000_2000; wb_line = wb_pat; mem_write = 1'b1; mem_read = 1'b1;
        mm_ack = 1'b1;
        tick();
        mem_write = 1'b0; mem_read = 1'b0;
        for (int k = 0; k < WPL; k++) begin
            chk("both_wr_we", mm_we, 1);
            chk("both_wr_addr", mm_addr, 32'h2000 + 4 * k);
            chk("both_wr_data", mm_wdata, 32'h10 + k);
            tick();
        end
        chk("both_resp1", ca_resp, 1);
        chk("both_busy1", busy, 1);
        tick();
        for (int k = 0; k < WPL; k++) begin
            chk("both_rd_req", mm_req, 1);
            chk("both_rd_we", mm_we, 0);
            chk("both_rd_addr", mm_addr, 32'h2000 + 4 * k);
            tick();
        end
        chk("both_resp2", ca_resp, 1);
        chk("both_fill", fill_line, exp_fill);
        tick();
        chk("both_idle", busy, 0);
        chk("both_resp_cnt", resp_cnt - base, 2);

        // mem_read during a writeback is dropped.
        base = resp_cnt;
        line_addr = 32'h0000_4000; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        for (int k = 0; k < WPL; k++) begin
            mem_read = (k == 3);
            tick();
        end
        mem_read = 1'b0;
        chk("ign_resp", ca_resp, 1);
        req_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            req_seen = req_seen | mm_req;
        end
        chk("ign_no_read", req_seen, 0);
        chk("ign_resp_cnt", resp_cnt - base, 1);

        // Reset at word 4 of a fill aborts without a response.
        base = resp_cnt;
        line_addr = 32'h0000_3000; mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_mid_addr", mm_addr, 32'h3010);
        rst = 1'b1;
        tick();
        chk("rst_mid_req", mm_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_fill", fill_line, 0);
        chk("rst_mid_resp", ca_resp, 0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("rst_mid_resp_cnt", resp_cnt - base, 0);

        // Word never acknowledged.
        base = resp_cnt;
        mm_ack = 1'b0; line_addr = 32'h0000_6000; mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
`ifdef LINE_XFER_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            chk("to_wait_req", mm_req, 1);
            chk("to_wait_resp", ca_resp, 0);
            tick();
        end
        chk("to_resp", ca_resp, 1);
        chk("to_err", xfer_err, 1);
        tick();
        chk("to_idle", busy, 0);
        chk("to_err_clr", xfer_err, 0);
`else
        for (int c = 0; c < 1000; c++) tick();
        chk("nto_busy", busy, 1);
        chk("nto_req", mm_req, 1);
        chk("nto_addr", mm_addr, 32'h6000);
        chk("nto_err", xfer_err, 0);
        chk("nto_resp_cnt", resp_cnt - base, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so a stuck design still ends the run.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, observed busy=%0b expected completion", busy);
        $fatal(1, "bench timeout");
    end

endmodule
